// File: rtl/slv_guard_rst_seq.sv
// Recovery sequencer for a misbehaving AXI subordinate: isolate new requests,
// drain outstanding transactions (bounded), hold the subordinate in reset, release.
module slv_guard_rst_seq #(
  parameter int MaxOutstanding = 16,
  parameter int DrainCycles    = 1024,
  parameter int CntWidth       = 16,
  parameter int OutW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rst_req_i,
  input  logic [CntWidth-1:0] rst_len_i,
  input  logic                aw_valid_i,
  input  logic                aw_ready_i,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic                clr_i,
  output logic                isolate_o,
  output logic                slv_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                drain_to_o,
  output logic [OutW-1:0]     wr_out_o,
  output logic [OutW-1:0]     rd_out_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    RESET,
    RELEASE,
    WAIT_DEASSERT
  } state_e;

  localparam logic [OutW-1:0]     OutMax    = OutW'(MaxOutstanding);
  localparam logic [CntWidth-1:0] DrainLast = CntWidth'(DrainCycles - 1);

  state_e              state;
  logic [CntWidth-1:0] timer;
  logic [CntWidth-1:0] rst_len_eff;
  logic                wr_inc, wr_dec, rd_inc, rd_dec;
  logic                drained;

  assign wr_inc      = aw_valid_i & aw_ready_i;
  assign wr_dec      = b_valid_i & b_ready_i;
  assign rd_inc      = ar_valid_i & ar_ready_i;
  assign rd_dec      = r_valid_i & r_ready_i & r_last_i;
  assign drained     = (wr_out_o == '0) && (rd_out_o == '0);
  // A zero hold length still pulses the subordinate reset for one cycle.
  assign rst_len_eff = (rst_len_i == '0) ? CntWidth'(1) : rst_len_i;

  // Outstanding counters: saturating, simultaneous inc/dec cancel, cleared while in RESET.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation order between blocks cannot matter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_out_o <= '0;
      rd_out_o <= '0;
    end else if (state == RESET) begin
      wr_out_o <= '0;
      rd_out_o <= '0;
    end else begin
      if (wr_inc && !wr_dec && wr_out_o != OutMax)
        wr_out_o <= wr_out_o + OutW'(1);
      else if (wr_dec && !wr_inc && wr_out_o != '0)
        wr_out_o <= wr_out_o - OutW'(1);

      if (rd_inc && !rd_dec && rd_out_o != OutMax)
        rd_out_o <= rd_out_o + OutW'(1);
      else if (rd_dec && !rd_inc && rd_out_o != '0)
        rd_out_o <= rd_out_o - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      timer      <= '0;
      isolate_o  <= 1'b0;
      slv_rst_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      drain_to_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clr_i) drain_to_o <= 1'b0;

      unique case (state)
        IDLE: begin
          timer <= '0;
          if (rst_req_i) begin
            state     <= ISOLATE;
            isolate_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        ISOLATE: begin
          // Later assignment to drain_to_o lets a timeout win over a same-cycle clear.
          if (drained || timer == DrainLast) begin
            state     <= RESET;
            timer     <= rst_len_eff;
            slv_rst_o <= 1'b1;
            if (!drained) drain_to_o <= 1'b1;
          end else begin
            timer <= timer + CntWidth'(1);
          end
        end
        RESET: begin
          if (timer == CntWidth'(1)) begin
            state     <= RELEASE;
            slv_rst_o <= 1'b0;
          end else begin
            timer <= timer - CntWidth'(1);
          end
        end
        RELEASE: begin
          state     <= WAIT_DEASSERT;
          isolate_o <= 1'b0;
        end
        WAIT_DEASSERT: begin
          // Parking here until the request drops prevents a stuck request from retriggering.
          if (!rst_req_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Self-checking bench for slv_guard_rst_seq: directed scenarios plus random traffic,
// compared every cycle against a phase/age-based behavioural model.
module tb_slv_guard_rst_seq;

  localparam int MaxOut = 16;
  localparam int Drain  = 8;
  localparam int CW     = 16;
  localparam int OW     = $clog2(MaxOut + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rst_req_i;
  logic [CW-1:0] rst_len_i;
  logic          aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
  logic          b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic          clr_i;
  logic          isolate_o, slv_rst_o, busy_o, done_o, drain_to_o;
  logic [OW-1:0] wr_out_o, rd_out_o;

  int checks = 0;
  int errors = 0;

  slv_guard_rst_seq #(
    .MaxOutstanding(MaxOut),
    .DrainCycles   (Drain),
    .CntWidth      (CW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rst_req_i (rst_req_i),
    .rst_len_i (rst_len_i),
    .aw_valid_i(aw_valid_i),
    .aw_ready_i(aw_ready_i),
    .ar_valid_i(ar_valid_i),
    .ar_ready_i(ar_ready_i),
    .b_valid_i (b_valid_i),
    .b_ready_i (b_ready_i),
    .r_valid_i (r_valid_i),
    .r_ready_i (r_ready_i),
    .r_last_i  (r_last_i),
    .clr_i     (clr_i),
    .isolate_o (isolate_o),
    .slv_rst_o (slv_rst_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .drain_to_o(drain_to_o),
    .wr_out_o  (wr_out_o),
    .rd_out_o  (rd_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a recovery episode is described by how long isolation has
  // lasted, how many reset cycles remain, and whether we are releasing or parked.
  int m_wr = 0, m_rd = 0;
  int m_iso_age = -1;
  int m_hold = 0;
  bit m_release = 0, m_parked = 0, m_done = 0, m_timeout = 0;

  function automatic int clip(input int v);
    return (v < 0) ? 0 : (v > MaxOut) ? MaxOut : v;
  endfunction

  task automatic model_step();
    int  hold_was;
    bit  to_set;
    if (rst_i) begin
      m_wr = 0; m_rd = 0; m_iso_age = -1; m_hold = 0;
      m_release = 0; m_parked = 0; m_done = 0; m_timeout = 0;
    end else begin
      hold_was = m_hold;
      to_set   = 0;
      m_done   = 0;
      if (m_parked) begin
        if (!rst_req_i) begin m_parked = 0; m_done = 1; end
      end else if (m_release) begin
        m_release = 0; m_parked = 1;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_release = 1;
      end else if (m_iso_age >= 0) begin
        if (m_wr == 0 && m_rd == 0 || m_iso_age == Drain - 1) begin
          to_set    = !(m_wr == 0 && m_rd == 0);
          m_iso_age = -1;
          m_hold    = (rst_len_i == 0) ? 1 : int'(rst_len_i);
        end else begin
          m_iso_age++;
        end
      end else if (rst_req_i) begin
        m_iso_age = 0;
      end
      if (clr_i) m_timeout = 0;
      if (to_set) m_timeout = 1;
      if (hold_was > 0) begin
        m_wr = 0; m_rd = 0;
      end else begin
        m_wr = clip(m_wr + int'(aw_valid_i && aw_ready_i) - int'(b_valid_i && b_ready_i));
        m_rd = clip(m_rd + int'(ar_valid_i && ar_ready_i)
                    - int'(r_valid_i && r_ready_i && r_last_i));
      end
    end
  endtask

  // Single compare process: model advances on each edge, DUT sampled 1 time unit later.
  always @(posedge clk_i) begin
    model_step();
    #1;
    check("isolate",  isolate_o,  (m_iso_age >= 0 || m_hold > 0 || m_release) ? 1 : 0);
    check("slv_rst",  slv_rst_o,  (m_hold > 0) ? 1 : 0);
    check("busy",     busy_o,     (m_iso_age >= 0 || m_hold > 0 || m_release || m_parked) ? 1 : 0);
    check("done",     done_o,     32'(m_done));
    check("drain_to", drain_to_o, 32'(m_timeout));
    check("wr_out",   wr_out_o,   m_wr);
    check("rd_out",   rd_out_o,   m_rd);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input bit aw, input bit ar, input bit b, input bit r);
    aw_valid_i = aw; aw_ready_i = aw;
    ar_valid_i = ar; ar_ready_i = ar;
    b_valid_i  = b;  b_ready_i  = b;
    r_valid_i  = r;  r_ready_i  = r;  r_last_i = r;
    tick();
    {aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i} = '0;
    {b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i} = '0;
  endtask

  // Walk the sequence until it parks (busy with isolation dropped), measuring phases.
  task automatic run_to_park(output int iso_cyc, output int rst_cyc);
    int n = 0;
    bit saw_rst = 0;
    iso_cyc = 0;
    rst_cyc = 0;
    while (!(busy_o && !isolate_o) && n < 200) begin
      if (slv_rst_o) begin
        rst_cyc++;
        saw_rst = 1;
      end else if (isolate_o && !saw_rst) begin
        iso_cyc++;
      end
      tick();
      n++;
    end
    check("park_reached", (n < 200) ? 1 : 0, 1);
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done_o) seen = 1;
    end
  endtask

  initial begin
    int iso_c, rst_c, bad;
    bit seen;
    rst_i = 1'b1;
    rst_req_i = 1'b0;
    rst_len_i = '0;
    clr_i = 1'b0;
    {aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i} = '0;
    {b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i} = '0;
    repeat (3) tick();
    check("rst_busy", busy_o, 0);
    check("rst_wr", wr_out_o, 0);
    rst_i = 1'b0;
    tick();

    // Idle traffic: 3 AW then 2 B leaves one write outstanding, no isolation.
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    check("idle_wr", wr_out_o, 1);
    check("idle_iso", isolate_o, 0);
    check("idle_slv_rst", slv_rst_o, 0);

    // Clean drain with rst_len 4.
    step(1, 1, 0, 0);
    check("drain_wr2", wr_out_o, 2);
    check("drain_rd1", rd_out_o, 1);
    rst_len_i = CW'(4);
    rst_req_i = 1'b1;
    tick();
    check("iso_one_cycle", isolate_o, 1);
    repeat (4) tick();
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    run_to_park(iso_c, rst_c);
    check("clean_rst_len", rst_c, 4);
    check("clean_no_to", drain_to_o, 0);
    rst_req_i = 1'b0;
    wait_done(seen);
    check("clean_done", 32'(seen), 1);

    // Drain timeout: one write never answered.
    step(1, 0, 0, 0);
    rst_len_i = CW'(3);
    rst_req_i = 1'b1;
    tick();
    run_to_park(iso_c, rst_c);
    check("to_iso_cycles", iso_c, Drain);
    check("to_rst_len", rst_c, 3);
    check("to_flag", drain_to_o, 1);
    check("to_wr_cleared", wr_out_o, 0);
    rst_req_i = 1'b0;
    wait_done(seen);
    check("to_done", 32'(seen), 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("to_cleared", drain_to_o, 0);

    // Counter boundaries.
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("simul_wr", wr_out_o, 2);
    repeat (20) step(1, 0, 0, 0);
    check("sat_wr", wr_out_o, 16);
    repeat (16) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("underflow_wr", wr_out_o, 0);

    // Zero length reset with a stuck request.
    rst_len_i = '0;
    rst_req_i = 1'b1;
    tick();
    run_to_park(iso_c, rst_c);
    check("len0_rst", rst_c, 1);
    check("park_iso", isolate_o, 0);
    check("park_busy", busy_o, 1);
    bad = 0;
    repeat (10) begin
      tick();
      if (done_o || isolate_o || !busy_o) bad++;
    end
    check("no_retrigger", bad, 0);
    rst_req_i = 1'b0;
    wait_done(seen);
    check("stuck_done", 32'(seen), 1);

    // Async reset while the subordinate is held in reset.
    rst_len_i = CW'(10);
    rst_req_i = 1'b1;
    for (int i = 0; i < 50 && !slv_rst_o; i++) tick();
    check("async_in_reset", slv_rst_o, 1);
    repeat (2) tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_slv_rst", slv_rst_o, 0);
    check("async_iso", isolate_o, 0);
    check("async_busy", busy_o, 0);
    rst_req_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    check("async_wr", wr_out_o, 0);
    check("async_rd", rd_out_o, 0);
    check("async_idle", busy_o, 0);

    // Random traffic, requests, lengths and clears against the model.
    for (int i = 0; i < 3000; i++) begin
      aw_valid_i = 1'($urandom_range(0, 1));
      aw_ready_i = 1'($urandom_range(0, 1));
      ar_valid_i = 1'($urandom_range(0, 1));
      ar_ready_i = 1'($urandom_range(0, 1));
      b_valid_i  = 1'($urandom_range(0, 1));
      b_ready_i  = 1'($urandom_range(0, 1));
      r_valid_i  = 1'($urandom_range(0, 1));
      r_ready_i  = 1'($urandom_range(0, 1));
      r_last_i   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) rst_req_i = !rst_req_i;
      rst_len_i = CW'($urandom_range(0, 6));
      clr_i = ($urandom_range(0, 15) == 0);
      tick();
    end
    {aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i} = '0;
    {b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i} = '0;
    clr_i = 1'b0;
    rst_req_i = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
